sad_search_scheduler: RTL and testbench

Sequences the custom SAD/motion-search datapath (EX1→EX2 custom-instruction path) across every candidate window position of a frame. It walks (x,y) in raster order, issues one position per handshake into the datapath, and limits in-flight positions with a credit counter. It collects the tagged SAD results, tracks the minimum SAD and its coordinates, and stalls the main pipeline while the search is running.

---
 rtl/sad_search_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sad_search_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_scheduler.sv
// sad_search_scheduler: walks every candidate window position of a frame in
// raster order, issues each position once to the SAD datapath under a credit
// limit, tracks the minimum returned SAD and its coordinates, and freezes the
// main pipeline while a search runs.
//
// Ports:
//   Clk, Reset                    clock (rising edge), async active-low reset
//   Start                         start a search (sampled only when idle)
//   FrameRows/FrameCols           frame dimensions
//   WinRows/WinCols               search window dimensions
//   IssueValid/IssueReady         position handshake, IssueX/IssueY candidate
//   ResultValid/ResultSAD/X/Y     in-order tagged SAD results
//   Busy, Stall, Done, Error      status (Stall is combinational)
//   BestSAD/BestX/BestY           minimum SAD found and its position
module sad_search_scheduler #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned SAD_W        = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [COORD_W-1:0] FrameRows,
  input  logic [COORD_W-1:0] FrameCols,
  input  logic [COORD_W-1:0] WinRows,
  input  logic [COORD_W-1:0] WinCols,
  input  logic               IssueReady,
  output logic               IssueValid,
  output logic [COORD_W-1:0] IssueX,
  output logic [COORD_W-1:0] IssueY,
  input  logic               ResultValid,
  input  logic [SAD_W-1:0]   ResultSAD,
  input  logic [COORD_W-1:0] ResultX,
  input  logic [COORD_W-1:0] ResultY,
  output logic               Busy,
  output logic               Stall,
  output logic               Done,
  output logic               Error,
  output logic [SAD_W-1:0]   BestSAD,
  output logic [COORD_W-1:0] BestX,
  output logic [COORD_W-1:0] BestY
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x_max_q, x_max_d, y_max_q, y_max_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               issue_valid_d, busy_d, done_d, error_d;
  logic [SAD_W-1:0]   best_sad_d;
  logic [COORD_W-1:0] best_x_d, best_y_d;
  logic               fire_c, result_ok_c, cfg_bad_c;

  // Candidate position is the walk register itself, so it holds until fire.
  assign IssueX = x_q;
  assign IssueY = y_q;

  // Pipeline freezes in the very cycle a Start is accepted.
  assign Stall = Busy | ((state_q == IDLE) & Start & Reset);

  // A result issued and returned in the same cycle is legitimate even with
  // no registered credit outstanding, so it counts alongside the fire.
  assign fire_c      = (state_q == ISSUE) & IssueValid & IssueReady;
  assign result_ok_c = ResultValid & ((inflight_q != CNT_W'(0)) | fire_c);
  assign cfg_bad_c   = (WinRows == '0) | (WinCols == '0) |
                       (WinRows > FrameRows) | (WinCols > FrameCols);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    x_max_d       = x_max_q;
    y_max_d       = y_max_q;
    inflight_d    = inflight_q;
    error_d       = Error;
    best_sad_d    = BestSAD;
    best_x_d      = BestX;
    best_y_d      = BestY;
    issue_valid_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    // Credit accounting: simultaneous fire and result cancel.
    if (fire_c && !result_ok_c) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!fire_c && result_ok_c) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    // Strict less-than keeps the earliest result on ties.
    if (result_ok_c && (ResultSAD < BestSAD)) begin
      best_sad_d = ResultSAD;
      best_x_d   = ResultX;
      best_y_d   = ResultY;
    end

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (cfg_bad_c) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            error_d    = 1'b0;
            best_sad_d = '1;
            best_x_d   = '0;
            best_y_d   = '0;
            x_d        = '0;
            y_d        = '0;
            x_max_d    = FrameCols - WinCols;
            y_max_d    = FrameRows - WinRows;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fire_c) begin
          if (x_q == x_max_q) begin
            x_d = '0;
            if (y_q == y_max_q) begin
              state_d = DRAIN;
            end else begin
              y_d = y_q + COORD_W'(1);
            end
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
      end
      DRAIN: begin
        if (inflight_q == CNT_W'(0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d        = (state_d == ISSUE) || (state_d == DRAIN);
    done_d        = (state_d == DONE);
    issue_valid_d = (state_d == ISSUE) && (inflight_d < CNT_W'(MAX_INFLIGHT));
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x_max_q    <= '0;
      y_max_q    <= '0;
      inflight_q <= '0;
      IssueValid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      BestSAD    <= '1;
      BestX      <= '0;
      BestY      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_max_q    <= x_max_d;
      y_max_q    <= y_max_d;
      inflight_q <= inflight_d;
      IssueValid <= issue_valid_d;
      Busy       <= busy_d;
      Done       <= done_d;
      Error      <= error_d;
      BestSAD    <= best_sad_d;
      BestX      <= best_x_d;
      BestY      <= best_y_d;
    end
  end

endmodule

// File: tb/tb_sad_search_scheduler.sv
// Randomized self-checking bench for sad_search_scheduler. A behavioural
// model enumerates positions by index, answers issues from a latency queue
// and keeps the running minimum SAD.
module tb_sad_search_scheduler;

  localparam int unsigned CW   = 10;
  localparam int unsigned SW   = 32;
  localparam int unsigned MAXI = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [CW-1:0] FrameRows = '0, FrameCols = '0, WinRows = '0, WinCols = '0;
  logic          IssueReady = 1'b0;
  logic          IssueValid;
  logic [CW-1:0] IssueX, IssueY;
  logic          ResultValid = 1'b0;
  logic [SW-1:0] ResultSAD = '0;
  logic [CW-1:0] ResultX = '0, ResultY = '0;
  logic          Busy, Stall, Done, Error;
  logic [SW-1:0] BestSAD;
  logic [CW-1:0] BestX, BestY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  sad_search_scheduler #(.COORD_W(CW), .SAD_W(SW), .MAX_INFLIGHT(MAXI)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .FrameRows(FrameRows), .FrameCols(FrameCols),
    .WinRows(WinRows), .WinCols(WinCols),
    .IssueReady(IssueReady), .IssueValid(IssueValid),
    .IssueX(IssueX), .IssueY(IssueY),
    .ResultValid(ResultValid), .ResultSAD(ResultSAD),
    .ResultX(ResultX), .ResultY(ResultY),
    .Busy(Busy), .Stall(Stall), .Done(Done), .Error(Error),
    .BestSAD(BestSAD), .BestX(BestX), .BestY(BestY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int sad;
    int due;
  } res_t;

  // Per-position SAD patterns for the directed scenarios; random otherwise.
  function automatic int sad_of(input int mode, input int x, input int y);
    if (mode == 1 || mode == 2) return (x == 1 && y == 2) ? 1 : 10 * y + x + 3;
    if (mode == 4) return ((x == 0 && y == 0) || (x == 2 && y == 1)) ? 5 : 9;
    return int'($urandom_range(0, 40));
  endfunction

  // Runs one valid search; caller is positioned #1 after a rising edge.
  // done_at = index of the post-edge sample (0 = edge accepting Start) at
  // which Done is first seen.
  task automatic run_search(input int fr, input int fc, input int wr, input int wc,
                            input int mode, output int done_at);
    res_t        pend[$];
    res_t        e;
    int          nx, ny, total, issued, inflight, bx, by, hold, lat, px, py;
    logic [31:0] best;
    bit          exp_iv, ready, fired, r, seen;
    nx = fc - wc + 1;
    ny = fr - wr + 1;
    total = nx * ny;
    issued = 0; inflight = 0; bx = 0; by = 0; hold = 0; best = '1;
    seen = 0; done_at = -1;
    FrameRows = CW'(fr); FrameCols = CW'(fc); WinRows = CW'(wr); WinCols = CW'(wc);
    Start = 1'b1;
    IssueReady = 1'b0;
    ResultValid = 1'b0;
    #1 check("stall_on_start", 64'(Stall), 64'(1));
    @(posedge Clk); #1;
    Start = 1'b0;
    // Config must be ignored once latched.
    FrameRows = CW'($urandom); FrameCols = CW'($urandom);
    WinRows = CW'($urandom); WinCols = CW'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (Done) begin
        seen = 1;
        done_at = i;
        break;
      end
      check("busy", 64'(Busy), 64'(1));
      check("stall", 64'(Stall), 64'(1));
      check("error_clear", 64'(Error), 64'(0));
      exp_iv = (issued < total) && (inflight < int'(MAXI));
      check("issue_valid", 64'(IssueValid), 64'(exp_iv));
      if (exp_iv) begin
        check("issue_x", 64'(IssueX), 64'(issued % nx));
        check("issue_y", 64'(IssueY), 64'(issued / nx));
      end
      case (mode)
        2: begin
          if (IssueValid && IssueX == CW'(2) && IssueY == CW'(0) && hold < 3) begin
            ready = 1'b0;
            hold++;
          end else begin
            ready = 1'b1;
          end
        end
        6: ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      IssueReady = ready;
      fired = exp_iv && ready;
      if (fired) begin
        px = issued % nx;
        py = issued / nx;
        lat = (mode == 1 || mode == 2) ? 2 : (mode == 5) ? 0 : int'($urandom_range(0, 3));
        pend.push_back('{px, py, sad_of(mode, px, py), i + 1 + lat});
        issued++;
      end
      r = 0;
      if (pend.size() > 0 && pend[0].due <= i + 1 &&
          (mode != 3 || i + 1 >= 40 || i + 1 == 20)) begin
        e = pend.pop_front();
        r = 1;
        ResultValid = 1'b1;
        ResultSAD = 32'(e.sad);
        ResultX = CW'(e.x);
        ResultY = CW'(e.y);
        if (32'(e.sad) < best) begin
          best = 32'(e.sad);
          bx = e.x;
          by = e.y;
        end
      end else begin
        ResultValid = 1'b0;
        ResultSAD = $urandom;
        ResultX = CW'($urandom);
        ResultY = CW'($urandom);
      end
      inflight = inflight + int'(fired) - int'(r);
      @(posedge Clk); #1;
    end
    ResultValid = 1'b0;
    IssueReady = 1'b0;
    if (!seen) begin
      check("done_timeout", 64'(Done), 64'(1));
    end else begin
      check("done_after_all_work", 64'(issued == total && inflight == 0), 64'(1));
      check("best_sad", 64'(BestSAD), 64'(best));
      check("best_x", 64'(BestX), 64'(bx));
      check("best_y", 64'(BestY), 64'(by));
      check("busy_at_done", 64'(Busy), 64'(0));
      check("stall_at_done", 64'(Stall), 64'(0));
      check("iv_at_done", 64'(IssueValid), 64'(0));
      @(posedge Clk); #1;
      check("done_one_pulse", 64'(Done), 64'(0));
    end
  endtask

  int d;

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_issue_valid", 64'(IssueValid), 64'(0));
    check("rst_best_sad", 64'(BestSAD), 64'(32'hFFFF_FFFF));
    check("rst_stall", 64'(Stall), 64'(0));
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("idle_busy", 64'(Busy), 64'(0));
    check("idle_done", 64'(Done), 64'(0));
    check("idle_error", 64'(Error), 64'(0));
    check("idle_best_xy", 64'({BestX, BestY}), 64'(0));

    // Raster walk with planted minimum at (1,2).
    run_search(4, 4, 2, 2, 1, d);
    check("t1_best_sad_const", 64'(BestSAD), 64'(1));
    check("t1_best_xy_const", 64'({BestX, BestY}), 64'({CW'(1), CW'(2)}));
    // Backpressure held at (2,0).
    run_search(4, 4, 2, 2, 2, d);
    // Credit limit with results withheld.
    run_search(8, 8, 1, 1, 3, d);
    // Tie keeps earliest; stray result while idle is ignored.
    run_search(4, 4, 2, 2, 4, d);
    ResultValid = 1'b1; ResultSAD = '0; ResultX = CW'(3); ResultY = CW'(3);
    @(posedge Clk); #1;
    ResultValid = 1'b0;
    check("stray_best_sad", 64'(BestSAD), 64'(5));
    check("stray_best_xy", 64'({BestX, BestY}), 64'(0));
    // Minimum latency: Done on the third sample counting the Start cycle.
    run_search(1, 1, 1, 1, 5, d);
    check("min_latency", 64'(d), 64'(2));

    // Invalid window wider than frame.
    FrameRows = CW'(4); FrameCols = CW'(4); WinRows = CW'(2); WinCols = CW'(5);
    Start = 1'b1;
    #1 check("bad_stall", 64'(Stall), 64'(1));
    @(posedge Clk); #1;
    Start = 1'b0;
    check("bad_done", 64'(Done), 64'(1));
    check("bad_error", 64'(Error), 64'(1));
    check("bad_no_issue", 64'(IssueValid), 64'(0));
    check("bad_busy", 64'(Busy), 64'(0));
    repeat (3) begin
      @(posedge Clk); #1;
      check("bad_error_held", 64'(Error), 64'(1));
      check("bad_done_low", 64'(Done), 64'(0));
      check("bad_no_issue_later", 64'(IssueValid), 64'(0));
    end
    run_search(3, 5, 2, 2, 6, d);

    // Asynchronous reset mid-search with three positions in flight.
    FrameRows = CW'(8); FrameCols = CW'(8); WinRows = CW'(1); WinCols = CW'(1);
    Start = 1'b1;
    IssueReady = 1'b1;
    ResultValid = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #3 Reset = 1'b0;
    #1;
    check("ares_issue_valid", 64'(IssueValid), 64'(0));
    check("ares_issue_xy", 64'({IssueX, IssueY}), 64'(0));
    check("ares_busy", 64'(Busy), 64'(0));
    check("ares_stall", 64'(Stall), 64'(0));
    check("ares_done", 64'(Done), 64'(0));
    check("ares_error", 64'(Error), 64'(0));
    check("ares_best_sad", 64'(BestSAD), 64'(32'hFFFF_FFFF));
    check("ares_best_xy", 64'({BestX, BestY}), 64'(0));
    @(posedge Clk); #1;
    check("ares_no_done", 64'(Done), 64'(0));
    Reset = 1'b1;
    IssueReady = 1'b0;
    @(posedge Clk); #1;
    run_search(8, 8, 1, 1, 3, d);

    // Random configurations and random backpressure/latency.
    repeat (4) begin
      int fr, fc;
      fr = int'($urandom_range(1, 6));
      fc = int'($urandom_range(1, 6));
      run_search(fr, fc, int'($urandom_range(1, fr)), int'($urandom_range(1, fc)), 6, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
